data_path: RTL and testbench
============================

Name: data_path

Overview:
- Datapath slave of the 8-bit computer. Executes the per-cycle control word issued by control_unit.
- Holds the architectural registers IR, MAR, PC, A, B and CCR, plus the ALU and both internal bus multiplexers.
- Returns IR and the CCR flags (CCR_Result) to control_unit. Drives address and write data toward memory.
- Sits between control_unit and the memory block inside the computer top level.

Parameters:
- WIDTH, 8, data/address width of every register and bus. CCR is always 4 bits.
- PC_RESET, 8'h00, value loaded into PC on reset.

Ports:
- Clk  input  1  system clock; all registers update on the rising edge
- Reset  input  1  synchronous, active-high reset
- IR_Load  input  1  IR <= Bus2
- MAR_Load  input  1  MAR <= Bus2
- PC_Load  input  1  PC <= Bus2
- PC_Inc  input  1  PC <= PC + 1
- A_Load  input  1  A <= Bus2
- B_Load  input  1  B <= Bus2
- CCR_Load  input  1  CCR <= ALU flags {N,Z,V,C}
- ALU_Sel  input  3  ALU operation select
- Bus1_Sel  input  2  Bus1 source select
- Bus2_Sel  input  2  Bus2 source select
- from_memory  input  WIDTH  memory read data
- IR  output  WIDTH  instruction register, to control_unit
- CCR_Result  output  4  {N,Z,V,C} register, to control_unit
- address  output  WIDTH  equals MAR register
- to_memory  output  WIDTH  equals Bus1, combinational

Behaviour:
- Reset (evaluated on the clock edge): IR, MAR, A, B = 0; CCR = 4'b0000; PC = PC_RESET. Reset overrides every load and increment in the same cycle.
- Bus1 mux (combinational):
  - 00 = PC, 01 = A, 10 = B.
  - 11 = 0 (defined, not X).
- Bus2 mux (combinational):
  - 00 = ALU_Result, 01 = Bus1, 10 = from_memory.
  - 11 = 0.
- ALU operands: X = B register, Y = Bus1. Result is WIDTH bits; the carry uses a WIDTH+1-bit internal sum.
  - 000 ADD: X+Y. C = carry out. V = (X[msb]==Y[msb]) && (R[msb]!=X[msb]).
  - 001 SUB: X-Y. C = borrow (X<Y unsigned). V = (X[msb]!=Y[msb]) && (R[msb]!=X[msb]).
  - 010 AND, 011 OR, 100 XOR: bitwise X,Y. V = 0, C = 0.
  - 101 NOT: ~Y. V = 0, C = 0.
  - 110 INC: Y+1. C = 1 when Y = all ones. V = 1 when Y = 8'h7F.
  - 111 DEC: Y-1. C = 1 when Y = 0. V = 1 when Y = 8'h80.
  - N = R[msb], Z = (R == 0) for all operations.
- ALU and flags are computed every cycle regardless of Bus2_Sel. CCR_Load captures them even when Bus2 does not select the ALU.
- Latency: any register load is visible one cycle after the edge on which its load strobe is high. address, IR and CCR_Result follow their registers with no extra delay.
- Simultaneous strobes: every asserted *_Load samples the same Bus2 value on the same edge; e.g. MAR_Load and A_Load together both get Bus2.
- PC:
  - PC_Load has priority over PC_Inc when both are high.
  - PC_Inc wraps 8'hFF -> 8'h00 with no flag effect.
  - A register loaded from Bus2 while Bus1 = PC sees the pre-increment PC value.
- Registers without a strobe hold their value. No internal state beyond the six registers.
- to_memory is Bus1 purely combinationally; memory's write strobe comes directly from control_unit and is not routed through this block.

Test Plan:
- Reset = 1 for one edge with PC_RESET = 8'h10, all strobes high -> next cycle PC = 8'h10; IR, MAR, A, B = 0; CCR_Result = 0000.
- LDA_IMM sequence, from_memory = 8'h86 then 8'h05:
  - Bus1_Sel = 00, Bus2_Sel = 01, MAR_Load -> address = PC.
  - Bus2_Sel = 10, IR_Load, PC_Inc -> IR = 8'h86, PC + 1.
  - Repeat for the operand with A_Load -> A = 8'h05.
- A = 8'h70, B = 8'h50, ALU_Sel = 000, Bus1_Sel = 01, Bus2_Sel = 00, B_Load, CCR_Load -> B = 8'hC0, CCR_Result = 1010 (N=1, Z=0, V=1, C=0).
- A = 8'h05, B = 8'h03, ALU_Sel = 001, CCR_Load -> flags N=1, C=1 (8'hFE). Then A = 8'h03 -> Z=1, C=0.
- PC = 8'hFF, PC_Inc -> 8'h00. Next, PC_Inc and PC_Load together with Bus2 = 8'h3C -> PC = 8'h3C.
- Bus1_Sel = 11 and Bus2_Sel = 11 with A_Load -> A = 0, to_memory = 0. ALU_Sel = 101 with Bus1 = A = 8'h0F -> Bus2 = 8'hF0, N=1.

Source files
------------

// File: rtl/data_path.sv
// data_path: register file, bus multiplexers and ALU executing the control word
// issued by control_unit each cycle.
module data_path #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IR_Load,
    input  logic             MAR_Load,
    input  logic             PC_Load,
    input  logic             PC_Inc,
    input  logic             A_Load,
    input  logic             B_Load,
    input  logic             CCR_Load,
    input  logic [2:0]       ALU_Sel,
    input  logic [1:0]       Bus1_Sel,
    input  logic [1:0]       Bus2_Sel,
    input  logic [WIDTH-1:0] from_memory,
    output logic [WIDTH-1:0] IR,
    output logic [3:0]       CCR_Result,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] to_memory
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] pc, mar, a, b, bus1, bus2, x, y, alu_r;
    logic [WIDTH:0]   sum, dif;
    logic             alu_v, alu_c;
    logic [3:0]       flags;

    assign bus1 = Bus1_Sel == 2'b00 ? pc :
                  Bus1_Sel == 2'b01 ? a  :
                  Bus1_Sel == 2'b10 ? b  : '0;
    assign bus2 = Bus2_Sel == 2'b00 ? alu_r :
                  Bus2_Sel == 2'b01 ? bus1  :
                  Bus2_Sel == 2'b10 ? from_memory : '0;

    assign x   = b;
    assign y   = bus1;
    assign sum = {1'b0, x} + {1'b0, y};
    assign dif = {1'b0, x} - {1'b0, y};

    always_comb begin
        alu_r = '0;
        alu_v = 1'b0;
        alu_c = 1'b0;
        case (ALU_Sel)
            3'b000: begin
                alu_r = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
            end
            3'b001: begin
                alu_r = dif[MSB:0];
                alu_c = dif[WIDTH];
                alu_v = (x[MSB] != y[MSB]) && (dif[MSB] != x[MSB]);
            end
            3'b010: alu_r = x & y;
            3'b011: alu_r = x | y;
            3'b100: alu_r = x ^ y;
            3'b101: alu_r = ~y;
            3'b110: begin
                alu_r = y + WIDTH'(1);
                alu_c = &y;
                alu_v = y == {1'b0, {MSB{1'b1}}};
            end
            default: begin
                alu_r = y - WIDTH'(1);
                alu_c = y == '0;
                alu_v = y == {1'b1, {MSB{1'b0}}};
            end
        endcase
    end

    assign flags = {alu_r[MSB], alu_r == '0, alu_v, alu_c};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            IR         <= '0;
            mar        <= '0;
            a          <= '0;
            b          <= '0;
            CCR_Result <= '0;
            pc         <= PC_RESET;
        end else begin
            if (IR_Load)  IR         <= bus2;
            if (MAR_Load) mar        <= bus2;
            if (A_Load)   a          <= bus2;
            if (B_Load)   b          <= bus2;
            if (CCR_Load) CCR_Result <= flags;
            if (PC_Load)     pc <= bus2;
            else if (PC_Inc) pc <= pc + WIDTH'(1);
        end
    end

    assign address   = mar;
    assign to_memory = bus1;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed vector table for the documented sequences, then random
// control words checked against an integer-arithmetic model of the datapath.
module tb_data_path;
    localparam logic [6:0] IRL = 7'h40, MARL = 7'h20, PCL = 7'h10, PCI = 7'h08,
                           AL = 7'h04, BL = 7'h02, CCRL = 7'h01;

    logic       Clk, Reset, IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [7:0] from_memory, IR, address, to_memory;
    logic [3:0] CCR_Result;

    data_path #(.WIDTH(8), .PC_RESET(8'h10)) dut (
        .Clk(Clk), .Reset(Reset), .IR_Load(IR_Load), .MAR_Load(MAR_Load),
        .PC_Load(PC_Load), .PC_Inc(PC_Inc), .A_Load(A_Load), .B_Load(B_Load),
        .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .from_memory(from_memory), .IR(IR), .CCR_Result(CCR_Result),
        .address(address), .to_memory(to_memory)
    );

    typedef struct {
        logic       rst;
        logic [6:0] ld;
        logic [2:0] alu;
        logic [1:0] b1, b2;
        logic [7:0] mem, tm, ir, addr;
        logic [3:0] ccr;
    } vec_t;

    vec_t tbl[32];
    int checks = 0, errors = 0;
    int m_pc, m_a, m_b, m_mar, m_ir;
    logic [3:0] m_ccr;

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mk(logic rst, logic [6:0] ld, logic [2:0] alu, logic [1:0] b1,
                                logic [1:0] b2, logic [7:0] mem, logic [7:0] tm,
                                logic [7:0] ir, logic [7:0] addr, logic [3:0] ccr);
        vec_t v;
        v.rst = rst; v.ld = ld; v.alu = alu; v.b1 = b1; v.b2 = b2;
        v.mem = mem; v.tm = tm; v.ir = ir; v.addr = addr; v.ccr = ccr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [6:0] ld, input logic [2:0] alu,
                         input logic [1:0] b1, input logic [1:0] b2, input logic [7:0] mem);
        Reset = rst;
        {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = ld;
        ALU_Sel = alu; Bus1_Sel = b1; Bus2_Sel = b2; from_memory = mem;
    endtask

    function automatic int sgn(int v);
        return v > 127 ? v - 256 : v;
    endfunction

    // Reference ALU in plain integer arithmetic; overflow is a signed range test.
    function automatic void alu_model(input int op, input int x, input int y,
                                      output int r, output logic [3:0] f);
        int s, sv;
        logic c, v;
        c = 0; sv = 0;
        case (op)
            0: begin s = x + y; c = s > 255; sv = sgn(x) + sgn(y); end
            1: begin s = x - y; c = x < y;   sv = sgn(x) - sgn(y); end
            2: s = x & y;
            3: s = x | y;
            4: s = x ^ y;
            5: s = 255 - y;
            6: begin s = y + 1; c = y == 255; sv = sgn(y) + 1; end
            default: begin s = y - 1; c = y == 0; sv = sgn(y) - 1; end
        endcase
        v = sv > 127 || sv < -128;
        r = s & 255;
        f = {r > 127, r == 0, v, c};
    endfunction

    function automatic int m_bus1(int sel);
        return sel == 0 ? m_pc : sel == 1 ? m_a : sel == 2 ? m_b : 0;
    endfunction

    task automatic model_edge(input logic rst, input logic [6:0] ld, input int alu,
                              input int b1, input int b2, input int mem);
        int r, bus2;
        logic [3:0] f;
        alu_model(alu, m_b, m_bus1(b1), r, f);
        bus2 = b2 == 0 ? r : b2 == 1 ? m_bus1(b1) : b2 == 2 ? mem : 0;
        if (rst) begin
            m_ir = 0; m_mar = 0; m_a = 0; m_b = 0; m_ccr = 0; m_pc = 8'h10;
        end else begin
            if (ld[6]) m_ir = bus2;
            if (ld[5]) m_mar = bus2;
            if (ld[2]) m_a = bus2;
            if (ld[1]) m_b = bus2;
            if (ld[0]) m_ccr = f;
            if (ld[4]) m_pc = bus2;
            else if (ld[3]) m_pc = (m_pc + 1) % 256;
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 7'h7F,     0, 1, 2, 8'hAA, 8'h00, 8'h00, 8'h00, 4'h0);
        tbl[1]  = mk(0, MARL,      0, 0, 1, 8'h00, 8'h10, 8'h00, 8'h10, 4'h0);
        tbl[2]  = mk(0, IRL|PCI,   0, 0, 2, 8'h86, 8'h10, 8'h86, 8'h10, 4'h0);
        tbl[3]  = mk(0, MARL,      0, 0, 1, 8'h00, 8'h11, 8'h86, 8'h11, 4'h0);
        tbl[4]  = mk(0, AL|PCI,    0, 0, 2, 8'h05, 8'h11, 8'h86, 8'h11, 4'h0);
        tbl[5]  = mk(0, MARL,      0, 1, 1, 8'h00, 8'h05, 8'h86, 8'h05, 4'h0);
        tbl[6]  = mk(0, AL,        0, 0, 2, 8'h70, 8'h12, 8'h86, 8'h05, 4'h0);
        tbl[7]  = mk(0, BL,        0, 0, 2, 8'h50, 8'h12, 8'h86, 8'h05, 4'h0);
        tbl[8]  = mk(0, BL|CCRL,   0, 1, 0, 8'h00, 8'h70, 8'h86, 8'h05, 4'hA);
        tbl[9]  = mk(0, MARL,      0, 2, 1, 8'h00, 8'hC0, 8'h86, 8'hC0, 4'hA);
        tbl[10] = mk(0, AL,        0, 0, 2, 8'h05, 8'h12, 8'h86, 8'hC0, 4'hA);
        tbl[11] = mk(0, BL,        0, 0, 2, 8'h03, 8'h12, 8'h86, 8'hC0, 4'hA);
        tbl[12] = mk(0, CCRL,      1, 1, 0, 8'h00, 8'h05, 8'h86, 8'hC0, 4'h9);
        tbl[13] = mk(0, AL,        0, 1, 2, 8'h03, 8'h05, 8'h86, 8'hC0, 4'h9);
        tbl[14] = mk(0, CCRL,      1, 1, 0, 8'h00, 8'h03, 8'h86, 8'hC0, 4'h4);
        tbl[15] = mk(0, PCL,       0, 0, 2, 8'hFF, 8'h12, 8'h86, 8'hC0, 4'h4);
        tbl[16] = mk(0, PCI,       0, 0, 0, 8'h00, 8'hFF, 8'h86, 8'hC0, 4'h4);
        tbl[17] = mk(0, PCL|PCI,   0, 0, 2, 8'h3C, 8'h00, 8'h86, 8'hC0, 4'h4);
        tbl[18] = mk(0, MARL,      0, 0, 1, 8'h00, 8'h3C, 8'h86, 8'h3C, 4'h4);
        tbl[19] = mk(0, AL,        0, 3, 3, 8'h55, 8'h00, 8'h86, 8'h3C, 4'h4);
        tbl[20] = mk(0, MARL,      0, 1, 1, 8'h00, 8'h00, 8'h86, 8'h00, 4'h4);
        tbl[21] = mk(0, AL,        0, 3, 2, 8'h0F, 8'h00, 8'h86, 8'h00, 4'h4);
        tbl[22] = mk(0, MARL|CCRL, 5, 1, 0, 8'h00, 8'h0F, 8'h86, 8'hF0, 4'h8);
        tbl[23] = mk(0, AL|PCI,    0, 0, 1, 8'h00, 8'h3C, 8'h86, 8'hF0, 4'h8);
        tbl[24] = mk(0, MARL,      0, 1, 1, 8'h00, 8'h3C, 8'h86, 8'h3C, 4'h8);
        tbl[25] = mk(0, 7'h00,     0, 0, 0, 8'h00, 8'h3D, 8'h86, 8'h3C, 4'h8);
        tbl[26] = mk(0, AL,        0, 0, 2, 8'h7F, 8'h3D, 8'h86, 8'h3C, 4'h8);
        tbl[27] = mk(0, CCRL,      6, 1, 0, 8'h00, 8'h7F, 8'h86, 8'h3C, 4'hA);
        tbl[28] = mk(0, AL,        0, 1, 2, 8'h80, 8'h7F, 8'h86, 8'h3C, 4'hA);
        tbl[29] = mk(0, CCRL,      7, 1, 2, 8'h00, 8'h80, 8'h86, 8'h3C, 4'h2);
        tbl[30] = mk(0, AL,        0, 1, 2, 8'hFF, 8'h80, 8'h86, 8'h3C, 4'h2);
        tbl[31] = mk(0, CCRL,      6, 1, 0, 8'h00, 8'hFF, 8'h86, 8'h3C, 4'h5);

        drive(1, 7'h00, 0, 0, 0, 8'h00);
        @(posedge Clk);
        foreach (tbl[i]) begin
            @(negedge Clk);
            drive(tbl[i].rst, tbl[i].ld, tbl[i].alu, tbl[i].b1, tbl[i].b2, tbl[i].mem);
            #1 chk($sformatf("vec%0d to_memory", i), to_memory, tbl[i].tm);
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d IR", i), IR, tbl[i].ir);
            chk($sformatf("vec%0d address", i), address, tbl[i].addr);
            chk($sformatf("vec%0d CCR", i), CCR_Result, tbl[i].ccr);
        end

        @(negedge Clk);
        drive(1, 7'h00, 0, 0, 0, 8'h00);
        model_edge(1, 7'h00, 0, 0, 0, 0);
        @(posedge Clk);
        for (int n = 0; n < 3000; n++) begin
            logic       rst;
            logic [6:0] ld;
            logic [2:0] alu;
            logic [1:0] b1, b2;
            logic [7:0] mem;
            rst = $urandom_range(63) == 0;
            ld  = 7'($urandom);
            alu = 3'($urandom);
            b1  = 2'($urandom);
            b2  = 2'($urandom);
            mem = $urandom_range(3) == 0 ? ($urandom_range(1) ? 8'hFF : 8'h7F) : 8'($urandom);
            @(negedge Clk);
            drive(rst, ld, alu, b1, b2, mem);
            #1 chk("rand to_memory", to_memory, m_bus1(b1));
            model_edge(rst, ld, alu, b1, b2, mem);
            @(posedge Clk);
            #1;
            chk("rand IR", IR, m_ir);
            chk("rand address", address, m_mar);
            chk("rand CCR", CCR_Result, m_ccr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
